// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register.
// Owns the PC, redirects on flush and counts stalled cycles.
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] IMemData,
  output logic [31:0] IMemAddr,
  output logic [31:0] Instr_ID,
  output logic [31:0] PCPlus4_ID,
  output logic        Valid_ID,
  output logic [4:0]  Rs_ID,
  output logic [4:0]  Rt_ID,
  output logic [15:0] StallCount
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam logic [31:0] PcRst = {PC_RESET[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      Flush: begin
        pc_d   = {BranchTarget[31:2], 2'b00};
        ifid_d = '{instr: NOP, pc4: 32'd0, valid: 1'b0};
      end
      Stall && !Flush: begin
        // Saturate so a long hang is still visible as all-ones.
        if (cnt_q != 16'hFFFF)
          cnt_d = cnt_q + 16'd1;
      end
      default: begin
        pc_d   = pc_inc;
        ifid_d = '{instr: IMemData, pc4: pc_inc, valid: 1'b1};
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q   <= PcRst;
      ifid_q <= '{instr: NOP, pc4: 32'd0, valid: 1'b0};
      cnt_q  <= 16'd0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign IMemAddr   = pc_q;
  assign Instr_ID   = ifid_q.instr;
  assign PCPlus4_ID = ifid_q.pc4;
  assign Valid_ID   = ifid_q.valid;
  assign Rs_ID      = ifid_q.instr[25:21];
  assign Rt_ID      = ifid_q.instr[20:16];
  assign StallCount = cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed plan plus random
// stall/flush/reset traffic against a cycle-level model.
module tb_if_id_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic [31:0] IMemData;
  logic [31:0] IMemAddr, Instr_ID, PCPlus4_ID;
  logic        Valid_ID;
  logic [4:0]  Rs_ID, Rt_ID;
  logic [15:0] StallCount;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_cnt;

  always #5 Clk = ~Clk;

  assign IMemData = IMemAddr | 32'hA000_0000;

  if_id_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .BranchTarget(BranchTarget), .IMemData(IMemData),
    .IMemAddr(IMemAddr), .Instr_ID(Instr_ID),
    .PCPlus4_ID(PCPlus4_ID), .Valid_ID(Valid_ID),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .StallCount(StallCount)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"}, IMemAddr, m_pc);
    check({tag, ".instr"}, Instr_ID, m_instr);
    check({tag, ".pc4"}, PCPlus4_ID, m_pc4);
    check({tag, ".valid"}, {31'd0, Valid_ID}, {31'd0, m_valid});
    check({tag, ".rs"}, {27'd0, Rs_ID}, {27'd0, m_instr[25:21]});
    check({tag, ".rt"}, {27'd0, Rt_ID}, {27'd0, m_instr[20:16]});
    check({tag, ".cnt"}, {16'd0, StallCount}, m_cnt);
  endtask

  // One clock: apply inputs, advance model with pre-edge state.
  task automatic step(input logic rst, input logic stl,
                      input logic fl, input logic [31:0] bt,
                      input bit do_chk, input string tag);
    Reset = rst; Stall = stl; Flush = fl; BranchTarget = bt;
    @(posedge Clk);
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
    end else if (fl) begin
      m_pc = bt & ~32'd3;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (stl) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_instr = m_pc | 32'hA000_0000;
      m_pc = m_pc + 4;
      m_pc4 = m_pc;
      m_valid = 1;
    end
    #1;
    if (do_chk) check_all(tag);
  endtask

  initial begin
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
    #1;
    step(1, 1, 0, 0, 1, "rst0");
    step(1, 1, 0, 0, 1, "rst1");
    check("rst.addr", IMemAddr, 32'h0);
    check("rst.valid", {31'd0, Valid_ID}, 32'd0);

    step(0, 0, 0, 0, 1, "adv1");
    check("p1.addr4", IMemAddr, 32'h4);
    check("p1.instr0", Instr_ID, 32'hA000_0000);
    check("p1.valid", {31'd0, Valid_ID}, 32'd1);
    step(0, 0, 0, 0, 1, "adv2");
    check("p1.addr8", IMemAddr, 32'h8);
    check("p1.pc4", PCPlus4_ID, 32'h8);

    step(0, 1, 0, 0, 1, "st1");
    step(0, 1, 0, 0, 1, "st2");
    check("p2.addr", IMemAddr, 32'h8);
    check("p2.instr", Instr_ID, 32'hA000_0004);
    check("p2.cnt", {16'd0, StallCount}, 32'd2);
    step(0, 0, 0, 0, 1, "st_rel");
    check("p2.instr8", Instr_ID, 32'hA000_0008);

    step(0, 0, 1, 32'h0000_0103, 1, "fl");
    check("p3.addr", IMemAddr, 32'h100);
    check("p3.instr", Instr_ID, 32'h0);
    step(0, 0, 0, 0, 1, "fl_adv");
    check("p3.tgt", Instr_ID, 32'hA000_0100);

    step(0, 1, 1, 32'h200, 1, "flst");
    check("p4.addr", IMemAddr, 32'h200);
    check("p4.cnt", {16'd0, StallCount}, 32'd2);

    step(0, 1, 0, 0, 1, "pre_rst");
    step(1, 1, 0, 0, 1, "rst_st");
    check("p5.cnt", {16'd0, StallCount}, 32'd0);
    step(0, 0, 1, 32'hFFFF_FFFC, 1, "fl_top");
    step(0, 0, 0, 0, 1, "wrap");
    check("p5.addr", IMemAddr, 32'h0);
    check("p5.pc4", PCPlus4_ID, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 2, r < 35, (r >= 90) || (r == 1),
           $urandom, 1, "rnd");
    end

    step(1, 1, 0, 0, 1, "rst_sat");
    for (int i = 0; i < 70000; i++)
      step(0, 1, 0, 0, (i == 65533) || (i == 65534) || (i == 65535), "sat");
    check("p6.cnt", {16'd0, StallCount}, 32'h0000_FFFF);
    step(0, 0, 0, 0, 1, "sat_adv");
    check("p6.hold", {16'd0, StallCount}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
